// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC vectoring engine.
// Angles use the binary convention where pi maps to 2^(Width-1).
// The master tables are held at 32-bit precision and rounded down
// to the instance width by the helper functions below.
package cordic_pkg;

    // Control states of the vectoring engine.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ITER = 3'd2,
        ST_GAIN = 3'd3,
        ST_DONE = 3'd4
    } cordic_state_t;

    // atan(2^-i) as a binary angle with pi = 2^31, for i = 0..31.
    localparam logic [31:0] ATAN_TABLE_32 [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Inverse CORDIC gain 0.6072529350 scaled by 2^31.
    localparam logic [31:0] CORDIC_K_32 = 32'd1304065748;

    // Rescale a 2^31-based constant to a 2^(width-1) base, rounding to nearest.
    function automatic logic [31:0] scale_const(input logic [31:0] v, input int width);
        logic [32:0] acc;
        if (width >= 32) begin
            return v;
        end
        acc = {1'b0, v} + (33'd1 << (31 - width));
        return 32'(acc >> (32 - width));
    endfunction

    // Binary-angle atan(2^-i) at the requested angle width.
    function automatic logic [31:0] atan_const(input int i, input int width);
        return scale_const(ATAN_TABLE_32[i[4:0]], width);
    endfunction

    // CORDIC_K in Q1.(width-1).
    function automatic logic [31:0] cordic_k(input int width);
        return scale_const(CORDIC_K_32, width);
    endfunction

endpackage

// File: rtl/adder_sel.sv
// Shared add-or-subtract cell: d=1 adds b to a, d=0 subtracts b from a.
module adder_sel #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             d,
    output logic [Width-1:0] s
);

    // Select between sum and difference.
    always_comb begin
        s = d ? (a + b) : (a - b);
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: converts (x, y) into magnitude and
// binary angle, one micro-rotation per clock, with a valid/ready handshake
// on both sides.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a GAIN state that scales
// the magnitude by CORDIC_K so mag_o is the true vector length.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int Width      = 16,
    parameter int Iterations = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [Width-1:0] x_i,
    input  logic signed [Width-1:0] y_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [Width+1:0] mag_o,
    output logic signed [Width-1:0] angle_o
);

    // Two guard bits: one for negating -2^(Width-1), one for CORDIC growth.
    localparam int DW     = Width + 2;
    localparam int ITER_W = $clog2(Width);
    localparam logic [Width-1:0] Z_QUARTER = Width'(1) << (Width - 2);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(Iterations - 1);

    cordic_state_t state_reg, state_next;

    logic signed [DW-1:0]    x_reg, y_reg;
    logic [Width-1:0]        z_reg;
    logic [ITER_W-1:0]       iter_reg;
    logic                    zero_reg;
    logic [DW-1:0]           mag_reg;
    logic [Width-1:0]        angle_reg;

    logic                    dir_neg;
    logic                    last_iter;
    logic signed [DW-1:0]    x_sh, y_sh;
    logic [Width-1:0]        z_next;

    logic [Width-1:0]        atan_rom [Width];
    logic [DW-1:0]           lane_a   [2];
    logic [DW-1:0]           lane_b   [2];
    logic                    lane_add [2];
    logic [DW-1:0]           lane_sum [2];

    genvar gi;

    // Arctangent constants for every possible step index.
    generate
        for (gi = 0; gi < Width; gi++) begin : g_atan
            assign atan_rom[gi] = Width'(atan_const(gi, Width));
        end
    endgenerate

    assign dir_neg   = y_reg[DW-1];
    assign last_iter = (iter_reg == ITER_LAST);
    assign x_sh      = x_reg >>> iter_reg;
    assign y_sh      = y_reg >>> iter_reg;

    // Lane 0 updates x, lane 1 updates y; rotation direction follows sign of y.
    always_comb begin
        lane_a[0]   = x_reg;
        lane_b[0]   = y_sh;
        lane_add[0] = ~dir_neg;
        lane_a[1]   = y_reg;
        lane_b[1]   = x_sh;
        lane_add[1] = dir_neg;
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            adder_sel #(
                .Width (DW)
            ) u_adder (
                .a (lane_a[gi]),
                .b (lane_b[gi]),
                .d (lane_add[gi]),
                .s (lane_sum[gi])
            );
        end
    endgenerate

    // Angle accumulator step; wraps modulo 2^Width by construction.
    always_comb begin
        z_next = dir_neg ? (z_reg - atan_rom[iter_reg]) : (z_reg + atan_rom[iter_reg]);
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = 2 * Width + 3;
    localparam logic [Width-1:0] K_W = Width'(cordic_k(Width));

    logic signed [PW-1:0] gain_x_ext, gain_k_ext, gain_prod, gain_round;
    logic [DW-1:0]        gain_mag;
    logic                 unused_gain;

    // x * K in Q1.(Width-1), rounded to nearest integer magnitude.
    assign gain_x_ext  = PW'(x_reg);
    assign gain_k_ext  = PW'(K_W);
    assign gain_prod   = gain_x_ext * gain_k_ext;
    assign gain_round  = gain_prod + (PW'(1) <<< (Width - 2));
    assign gain_mag    = gain_round[Width-1 +: DW];
    assign unused_gain = ^{gain_round[Width-2:0], gain_round[PW-1:Width-1+DW]};
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                state_next = ST_ITER;
            end
            ST_ITER: begin
                if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = ST_GAIN;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_GAIN: begin
                state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture, quadrant fold, micro-rotations, result latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            zero_reg  <= 1'b0;
            mag_reg   <= '0;
            angle_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_i) begin
                        x_reg    <= DW'(x_i);
                        y_reg    <= DW'(y_i);
                        z_reg    <= '0;
                        zero_reg <= (x_i == '0) && (y_i == '0);
                    end
                end
                ST_PRE: begin
                    iter_reg <= '0;
                    if (x_reg[DW-1] && !y_reg[DW-1]) begin
                        x_reg <= y_reg;
                        y_reg <= -x_reg;
                        z_reg <= Z_QUARTER;
                    end else if (x_reg[DW-1]) begin
                        x_reg <= -y_reg;
                        y_reg <= x_reg;
                        z_reg <= -Z_QUARTER;
                    end
                end
                ST_ITER: begin
                    x_reg    <= lane_sum[0];
                    y_reg    <= lane_sum[1];
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
                    // The zero vector never rotates, so its angle is forced to 0.
                    if (last_iter) begin
                        mag_reg   <= lane_sum[0];
                        angle_reg <= zero_reg ? '0 : z_next;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                ST_GAIN: begin
                    mag_reg   <= gain_mag;
                    angle_reg <= zero_reg ? '0 : z_reg;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign mag_o   = mag_reg;
    assign angle_o = angle_reg;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring (Width=16, Iterations=14).
// Expected magnitude/angle come from a real-valued model pushed to a
// scoreboard queue at stimulus time and popped when the result appears.
`timescale 1ns/1ps
module tb_cordic_vectoring;

    localparam int WIDTH      = 16;
    localparam int ITERATIONS = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LATENCY  = ITERATIONS + 3;
    localparam real MAG_GAIN = 1.0;
    localparam int  MAG_TOL  = 3;
`else
    localparam int  LATENCY  = ITERATIONS + 2;
    localparam real MAG_GAIN = 1.6467602;
    localparam int  MAG_TOL  = 6;
`endif
    localparam int  ANGLE_TOL = 8;
    localparam real PI        = 3.14159265358979;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_i;
    logic                    ready_o;
    logic signed [WIDTH-1:0] x_i;
    logic signed [WIDTH-1:0] y_i;
    logic                    valid_o;
    logic                    ready_i;
    logic signed [WIDTH+1:0] mag_o;
    logic signed [WIDTH-1:0] angle_o;

    typedef struct {
        int x;
        int y;
        int mag;
        int angle;
        bit exact;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cordic_vectoring #(
        .Width      (WIDTH),
        .Iterations (ITERATIONS)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .x_i     (x_i),
        .y_i     (y_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mag_o   (mag_o),
        .angle_o (angle_o)
    );

    // Compare with tolerance; modulus != 0 compares on a circle of that size.
    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol, input longint modulus);
        longint diff;
        checks++;
        diff = obs - exp;
        if (modulus != 0) begin
            diff = diff % modulus;
            if (diff > modulus / 2)  diff -= modulus;
            if (diff < -modulus / 2) diff += modulus;
        end
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic exp_t make_expect(input int x, input int y);
        exp_t e;
        real  m;
        e.x     = x;
        e.y     = y;
        e.exact = (x == 0 && y == 0);
        m       = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * MAG_GAIN;
        e.mag   = int'(m);
        e.angle = e.exact ? 0 : int'($atan2(real'(y), real'(x)) / PI * 32768.0);
        return e;
    endfunction

    // One transaction; hold > 0 stalls the result for that many cycles.
    task automatic run_sample(input int x, input int y, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   waited;
        logic signed [WIDTH+1:0] mag_hold;
        logic signed [WIDTH-1:0] ang_hold;
        e       = make_expect(x, y);
        ready_i = (hold == 0);
        waited  = 0;
        while (!ready_o && waited < 50) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", longint'(ready_o), 1, 0, 0);
        valid_i = 1'b1;
        x_i     = WIDTH'(x);
        y_i     = WIDTH'(y);
        sb_q.push_back(e);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        valid_i = 1'b0;
        x_i     = WIDTH'($urandom);
        y_i     = WIDTH'($urandom);
        while (!valid_o && lat < LATENCY + 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, LATENCY, 0, 0);
        mag_hold = mag_o;
        ang_hold = angle_o;
        for (int k = 0; k < hold; k++) begin
            valid_i = 1'b1;
            x_i     = WIDTH'($urandom);
            y_i     = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", longint'(valid_o), 1, 0, 0);
            check("hold_ready", longint'(ready_o), 0, 0, 0);
            check("hold_mag", mag_o, mag_hold, 0, 0);
            check("hold_angle", angle_o, ang_hold, 0, 0);
        end
        valid_i = 1'b0;
        got = sb_q.pop_front();
        $display("sample x=%0d y=%0d: mag=%0d (model %0d) angle=%0d (model %0d) latency=%0d",
                 got.x, got.y, mag_o, got.mag, angle_o, got.angle, lat);
        check("mag", mag_o, got.mag, got.exact ? 0 : MAG_TOL, 0);
        check("angle", angle_o, got.angle, got.exact ? 0 : ANGLE_TOL, 65536);
        check("mag_nonneg", longint'(mag_o < 0), 0, 0, 0);
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("released_valid", longint'(valid_o), 0, 0, 0);
        check("released_ready", longint'(ready_o), 1, 0, 0);
    endtask

    // Abandon a sample with reset during the sixth micro-rotation cycle.
    task automatic reset_mid_iter(input int x, input int y);
        bit seen;
        check("ready_before_reset_sample", longint'(ready_o), 1, 0, 0);
        valid_i = 1'b1;
        x_i     = WIDTH'(x);
        y_i     = WIDTH'(y);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset during iteration 5 for x=%0d y=%0d", x, y);
        check("midreset_ready", longint'(ready_o), 1, 0, 0);
        check("midreset_valid", longint'(valid_o), 0, 0, 0);
        check("midreset_mag", mag_o, 0, 0, 0);
        check("midreset_angle", angle_o, 0, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 2 * LATENCY; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("no_result_after_reset", longint'(seen), 0, 0, 0);
    endtask

    initial begin
        int  rx;
        int  ry;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        x_i     = '0;
        y_i     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", longint'(ready_o), 1, 0, 0);
        check("reset_valid", longint'(valid_o), 0, 0, 0);
        check("reset_mag", mag_o, 0, 0, 0);
        check("reset_angle", angle_o, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        run_sample(16384, 16384, 0);
        run_sample(-16384, 0, 0);
        run_sample(0, -32768, 0);
        run_sample(0, 0, 0);
        run_sample(-32768, -32768, 0);
        run_sample(32767, -1, 0);
        run_sample(-20000, 9000, 0);
        run_sample(12000, 5000, 5);
        reset_mid_iter(-25000, -12000);
        run_sample(-3000, 31000, 0);
        for (int n = 0; n < 6; n++) begin
            do begin
                rx = int'($urandom_range(0, 65535)) - 32768;
                ry = int'($urandom_range(0, 65535)) - 32768;
            end while (longint'(rx) * rx + longint'(ry) * ry < 64'd67108864);
            run_sample(rx, ry, 0);
        end
        check("scoreboard_empty", sb_q.size(), 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
